// File: rtl/cpu_sequencer.sv
// Phase sequencer for a multi-cycle CPU: steps an 8-phase instruction cycle and
// handles run, pause, single-step and halt control, plus a saturating instruction count.
module cpu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        step_mode,
    input  logic        step,
    input  logic        halt,
    output logic [2:0]  phase,
    output logic        cpu_en,
    output logic        halted,
    output logic        paused,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StHalted
    } state_e;

    localparam logic [2:0] LastPhase  = 3'd7;
    localparam logic [2:0] HaltPhase  = 3'd4;
    localparam logic [15:0] CountMax  = 16'hFFFF;

    state_e      state_q;
    logic [2:0]  phase_q;
    logic [15:0] count_q;
    logic [15:0] count_inc;
    logic        stop_pend_q;
    logic        step_once_q;
    logic        halted_q;
    logic        paused_q;
    logic        halt_hit;
    logic        last_phase;
    logic        pause_now;

    assign halt_hit   = (phase_q == HaltPhase) && halt;
    assign last_phase = (phase_q == LastPhase);
    // A stop arriving on the boundary cycle itself still pauses at that boundary.
    assign pause_now  = step_mode || stop_pend_q || stop || step_once_q;

    always_comb begin
        count_inc = count_q;
        if (count_q != CountMax) begin
            count_inc = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            phase_q     <= 3'd0;
            count_q     <= 16'd0;
            stop_pend_q <= 1'b0;
            step_once_q <= 1'b0;
            halted_q    <= 1'b0;
            paused_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        phase_q <= 3'd0;
                    end
                end
                StRun: begin
                    // Halt at phase 4 wins over any pending stop or step_mode.
                    if (halt_hit) begin
                        state_q     <= StHalted;
                        phase_q     <= 3'd0;
                        count_q     <= count_inc;
                        stop_pend_q <= 1'b0;
                        step_once_q <= 1'b0;
                        halted_q    <= 1'b1;
                    end else if (last_phase) begin
                        phase_q <= 3'd0;
                        count_q <= count_inc;
                        if (pause_now) begin
                            state_q     <= StPaused;
                            stop_pend_q <= 1'b0;
                            step_once_q <= 1'b0;
                            paused_q    <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q + 3'd1;
                        if (stop) begin
                            stop_pend_q <= 1'b1;
                        end
                    end
                end
                StPaused: begin
                    if (start) begin
                        state_q     <= StRun;
                        phase_q     <= 3'd0;
                        step_once_q <= 1'b0;
                        paused_q    <= 1'b0;
                    end else if (step) begin
                        state_q     <= StRun;
                        phase_q     <= 3'd0;
                        step_once_q <= 1'b1;
                        paused_q    <= 1'b0;
                    end
                end
                StHalted: begin
                    if (start) begin
                        state_q  <= StRun;
                        phase_q  <= 3'd0;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    phase_q <= 3'd0;
                end
            endcase
        end
    end

    assign cpu_en      = (state_q == StRun);
    assign phase       = phase_q;
    assign halted      = halted_q;
    assign paused      = paused_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scenario bench for cpu_sequencer: expected output vectors are queued as each
// stimulus cycle is driven and popped for comparison once the DUT has clocked.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        step_mode;
    logic        step;
    logic        halt;
    logic [2:0]  phase;
    logic        cpu_en;
    logic        halted;
    logic        paused;
    logic [15:0] instr_count;

    int n_run;
    int n_fail;
    logic [21:0] exp_q[$];
    logic [21:0] e;
    wire  [21:0] obs = {phase, cpu_en, halted, paused, instr_count};

    cpu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .step_mode   (step_mode),
        .step        (step),
        .halt        (halt),
        .phase       (phase),
        .cpu_en      (cpu_en),
        .halted      (halted),
        .paused      (paused),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [21:0] vec(input int ph, input bit en, input bit hl,
                                        input bit ps, input int cnt);
        logic [2:0]  p3;
        logic [15:0] c16;
        p3  = ph[2:0];
        c16 = cnt[15:0];
        return {p3, en, hl, ps, c16};
    endfunction

    // One clock: inputs applied after the falling edge, sampled 1ns after the rising edge.
    task automatic tick(input logic s, input logic sp, input logic st, input logic h);
        @(negedge clk);
        start = s; stop = sp; step = st; halt = h;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; step = 1'b0; halt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; halt = 1'b0; step_mode = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; halt = 1'b0; step_mode = 1'b0;
        #3;
        exp_q.push_back(vec(0, 0, 0, 0, 0));
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_init got=%h exp=%h", obs, e); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(vec(0, 0, 0, 0, 0));
            tick(1'b0, 1'b1, 1'b1, 1'b1);
            e = exp_q.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL idle_ignore k=%0d got=%h exp=%h", k, obs, e); end
        end
        exp_q.push_back(vec(0, 1, 0, 0, 0));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL idle_start got=%h exp=%h", obs, e); end
    endtask

    task automatic test_continuous();
        do_reset();
        exp_q.push_back(vec(0, 1, 0, 0, 0));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL cont_start got=%h exp=%h", obs, e); end
        for (int j = 1; j <= 24; j++) begin
            exp_q.push_back(vec(j % 8, 1, 0, 0, j / 8));
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL cont j=%0d got=%h exp=%h", j, obs, e); end
        end
    endtask

    task automatic test_halt();
        do_reset();
        exp_q.push_back(vec(0, 1, 0, 0, 0));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL halt_start got=%h exp=%h", obs, e); end
        // halt at phase 2 is ignored; halt at phase 4 of the second instruction halts.
        for (int j = 1; j <= 13; j++) begin
            if (j < 13) exp_q.push_back(vec(j % 8, 1, 0, 0, j / 8));
            else        exp_q.push_back(vec(0, 0, 1, 0, 2));
            tick(1'b0, 1'b0, 1'b0, (j == 3) || (j == 13));
            e = exp_q.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL halt j=%0d got=%h exp=%h", j, obs, e); end
        end
        exp_q.push_back(vec(0, 0, 1, 0, 2));
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL halted_ignore got=%h exp=%h", obs, e); end
        exp_q.push_back(vec(0, 1, 0, 0, 2));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL halt_resume got=%h exp=%h", obs, e); end
        exp_q.push_back(vec(1, 1, 0, 0, 2));
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL halt_resume_ph1 got=%h exp=%h", obs, e); end
    endtask

    task automatic test_step_mode();
        do_reset();
        step_mode = 1'b1;
        exp_q.push_back(vec(0, 1, 0, 0, 0));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL step_start got=%h exp=%h", obs, e); end
        for (int j = 1; j <= 9; j++) begin
            if (j < 8) exp_q.push_back(vec(j, 1, 0, 0, 0));
            else       exp_q.push_back(vec(0, 0, 0, 1, 1));
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL step_first j=%0d got=%h exp=%h", j, obs, e); end
        end
        // Single step with step_mode cleared must still return to PAUSED.
        step_mode = 1'b0;
        exp_q.push_back(vec(0, 1, 0, 0, 1));
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL step_pulse got=%h exp=%h", obs, e); end
        for (int j = 1; j <= 8; j++) begin
            if (j < 8) exp_q.push_back(vec(j, 1, 0, 0, 1));
            else       exp_q.push_back(vec(0, 0, 0, 1, 2));
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL step_once j=%0d got=%h exp=%h", j, obs, e); end
        end
        // step together with start acts as start: continuous run.
        exp_q.push_back(vec(0, 1, 0, 0, 2));
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL step_and_start got=%h exp=%h", obs, e); end
        for (int j = 1; j <= 9; j++) begin
            exp_q.push_back(vec(j % 8, 1, 0, 0, 2 + j / 8));
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL step_cont j=%0d got=%h exp=%h", j, obs, e); end
        end
    endtask

    task automatic test_stop();
        do_reset();
        exp_q.push_back(vec(0, 1, 0, 0, 0));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL stop_start got=%h exp=%h", obs, e); end
        // stop+start at phase 2 pends the stop; a lone start at phase 4 is ignored.
        for (int j = 1; j <= 8; j++) begin
            if (j < 8) exp_q.push_back(vec(j, 1, 0, 0, 0));
            else       exp_q.push_back(vec(0, 0, 0, 1, 1));
            tick((j == 3) || (j == 5), (j == 3), 1'b0, 1'b0);
            e = exp_q.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL stop j=%0d got=%h exp=%h", j, obs, e); end
        end
        exp_q.push_back(vec(0, 0, 0, 1, 1));
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL stop_in_paused got=%h exp=%h", obs, e); end
        exp_q.push_back(vec(0, 1, 0, 0, 1));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL stop_restart got=%h exp=%h", obs, e); end
        for (int j = 1; j <= 9; j++) begin
            exp_q.push_back(vec(j % 8, 1, 0, 0, 1 + j / 8));
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL stop_nopend j=%0d got=%h exp=%h", j, obs, e); end
        end
    endtask

    task automatic test_priority();
        do_reset();
        exp_q.push_back(vec(0, 1, 0, 0, 0));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL prio_start got=%h exp=%h", obs, e); end
        for (int j = 1; j <= 5; j++) begin
            if (j < 5) exp_q.push_back(vec(j, 1, 0, 0, 0));
            else       exp_q.push_back(vec(0, 0, 1, 0, 1));
            tick(1'b0, (j == 2), 1'b0, (j == 5));
            e = exp_q.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL prio j=%0d got=%h exp=%h", j, obs, e); end
        end
        exp_q.push_back(vec(0, 1, 0, 0, 1));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL prio_restart got=%h exp=%h", obs, e); end
        for (int j = 1; j <= 9; j++) begin
            exp_q.push_back(vec(j % 8, 1, 0, 0, 1 + j / 8));
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL prio_cont j=%0d got=%h exp=%h", j, obs, e); end
        end
    endtask

    task automatic test_saturation();
        int c;
        do_reset();
        step_mode = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 8; j++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(vec(0, 0, 0, 1, 1));
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL sat_paused got=%h exp=%h", obs, e); end
        @(negedge clk);
        dut.count_q = 16'hFFFE;
        step_mode = 1'b0;
        exp_q.push_back(vec(0, 1, 0, 0, 32'hFFFE));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL sat_start got=%h exp=%h", obs, e); end
        for (int j = 1; j <= 29; j++) begin
            c = 32'hFFFE + j / 8;
            if (c > 32'hFFFF) c = 32'hFFFF;
            exp_q.push_back(vec(j % 8, 1, 0, 0, c));
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL sat j=%0d got=%h exp=%h", j, obs, e); end
        end
        // Now at phase 5: assert reset mid-cycle, away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        exp_q.push_back(vec(0, 0, 0, 0, 0));
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", obs, e); end
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(vec(0, 0, 0, 0, 0));
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL post_reset_idle got=%h exp=%h", obs, e); end
        exp_q.push_back(vec(0, 1, 0, 0, 0));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_run++;
        if (obs !== e) begin n_fail++; $display("FAIL post_reset_start got=%h exp=%h", obs, e); end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        test_reset();
        test_continuous();
        test_halt();
        test_step_mode();
        test_stop();
        test_priority();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
